norm_sched: RTL and testbench

- Shares one iterative leading-one normalizer between NUM_REQ requesters using round-robin arbitration.
- Sequences the normalizer with a small FSM: capture, shift until MSB=1, present result.
- Returns per request:
  - shift count (square), which is the left-shift needed to put the leading one at bit DW-1;
  - two div bits taken immediately below the leading one;
  - the normalized value;
  - the requester id.
- Sits in the Normalization stage, between the value producers and the downstream divide/square logic.

---
 rtl/norm_pkg.sv | 26 ++
 rtl/norm_rr_arb.sv | 54 +++++
 rtl/norm_sched.sv | 143 ++++++++++++++
 tb/tb_norm_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// -----------------------------------------------------------------------------
// norm_pkg
// Shared definitions for the norm_sched normalization scheduler.
//   DW, SW   : default data width and shift-count (square) width
//   state_t  : sequencer states IDLE / SHIFT / DONE
//   result_t : one normalization result (square, div bits, value, zero flag)
// -----------------------------------------------------------------------------
package norm_pkg;

  localparam int DW = 10;
  localparam int SW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SW-1:0] square;
    logic [1:0]    div;
    logic [DW-1:0] valout;
    logic          zero;
  } result_t;

endpackage

// File: rtl/norm_rr_arb.sv
// -----------------------------------------------------------------------------
// norm_rr_arb
// Purely combinational round-robin arbiter. The search starts at the requester
// after i_rr_ptr and wraps modulo NUM_REQ; the first asserted request wins.
// Ports:
//   i_req    [NUM_REQ] : request vector
//   i_rr_ptr [IDW]     : last granted requester (must be < NUM_REQ)
//   i_en               : arbitration enable; no grant when low
//   o_grant  [NUM_REQ] : one-hot grant (all zero when nothing wins)
//   o_idx    [IDW]     : encoded index of the winner
//   o_any              : a winner exists
// -----------------------------------------------------------------------------
module norm_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_rr_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  // Rotating priority search, nearest-after-pointer first.
  always_comb begin
    int w_j;
    w_j     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    if (i_en) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        // pointer is always a valid index, so one subtraction wraps it
        w_j = int'(i_rr_ptr) + i;
        if (w_j >= NUM_REQ) begin
          w_j = w_j - NUM_REQ;
        end else begin
          w_j = w_j;
        end
        if (!o_any && i_req[w_j]) begin
          o_any = 1'b1;
          o_idx = IDW'(w_j);
        end else begin
          o_any = o_any;
        end
      end
      o_grant[o_idx] = o_any;
    end else begin
      o_any = 1'b0;
    end
  end

endmodule

// File: rtl/norm_sched.sv
// -----------------------------------------------------------------------------
// norm_sched
// Shares one iterative leading-one normalizer between NUM_REQ requesters.
// A round-robin winner is captured in IDLE, shifted left in SHIFT until its
// MSB is set (or it is zero), and presented in DONE until out_ready.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req_valid/o_req_ready: per-requester handshake (ready one-hot or zero)
//   i_req_data             : requester k at bits [k*DW +: DW]
//   o_out_valid/i_out_ready: result handshake
//   o_out_id               : granted requester index
//   o_out_square           : left shift applied (0..DW-1)
//   o_out_div              : two bits just below the leading one
//   o_out_valout           : normalized value
//   o_out_zero             : captured value was zero
// Build option: define NORM_SHIFT2_EN to shift two bits per cycle when the top
// two bits are both zero (same results, shorter latency).
// -----------------------------------------------------------------------------
module norm_sched #(
  parameter int NUM_REQ = 4,
  parameter int DW      = norm_pkg::DW,
  parameter int SW      = norm_pkg::SW,
  parameter int IDW     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [NUM_REQ*DW-1:0] i_req_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [IDW-1:0]        o_out_id,
  output logic [SW-1:0]         o_out_square,
  output logic [1:0]            o_out_div,
  output logic [DW-1:0]         o_out_valout,
  output logic                  o_out_zero
);

  import norm_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DW-1:0]      r_work;
  logic [DW-1:0]      w_work_nxt;
  logic [SW-1:0]      r_cnt;
  logic [SW-1:0]      w_cnt_nxt;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     w_id_nxt;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_gidx;
  logic               w_gany;
  logic               w_done;

  norm_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .i_req    (i_req_valid),
    .i_rr_ptr (r_rr_ptr),
    .i_en     (r_state == IDLE),
    .o_grant  (w_grant),
    .o_idx    (w_gidx),
    .o_any    (w_gany)
  );

  // Grant is only issued in IDLE, so ready is zero in SHIFT and DONE.
  assign o_req_ready = w_grant;

  // Next-state and datapath update for the capture/shift/present sequence.
  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_id_nxt     = r_id;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_gany) begin
          w_work_nxt   = i_req_data[int'(w_gidx)*DW +: DW];
          w_id_nxt     = w_gidx;
          w_cnt_nxt    = '0;
          w_rr_ptr_nxt = w_gidx;
          w_state_nxt  = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_work[DW-1] || (r_work == '0)) begin
          w_state_nxt = DONE;
`ifdef NORM_SHIFT2_EN
        end else if (r_work[DW-1:DW-2] == 2'b00) begin
          // leading one sits at DW-3 or below, so a 2-bit step cannot overshoot
          w_work_nxt = {r_work[DW-3:0], 2'b00};
          w_cnt_nxt  = r_cnt + SW'(2);
`endif
        end else begin
          w_work_nxt = {r_work[DW-2:0], 1'b0};
          w_cnt_nxt  = r_cnt + SW'(1);
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_id     <= '0;
      r_rr_ptr <= IDW'(NUM_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_id     <= w_id_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Result fields come straight from registers and read zero outside DONE.
  assign w_done       = (r_state == DONE);
  assign o_out_valid  = w_done;
  assign o_out_valout = w_done ? r_work : '0;
  assign o_out_square = w_done ? r_cnt : '0;
  assign o_out_div    = w_done ? r_work[DW-2:DW-3] : 2'b00;
  assign o_out_zero   = w_done && (r_work == '0);
  assign o_out_id     = w_done ? r_id : '0;

endmodule

// File: tb/tb_norm_sched.sv
module tb_norm_sched;

  localparam int NUM_REQ = 4;
  localparam int DW      = 10;
  localparam int SW      = 5;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDW-1:0]        out_id;
  logic [SW-1:0]         out_square;
  logic [1:0]            out_div;
  logic [DW-1:0]         out_valout;
  logic                  out_zero;

  int n_total = 0;
  int n_pass  = 0;
  int m_ptr   = NUM_REQ - 1;

  norm_sched #(.NUM_REQ(NUM_REQ), .DW(DW), .SW(SW), .IDW(IDW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_data   (req_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_id     (out_id),
    .o_out_square (out_square),
    .o_out_div    (out_div),
    .o_out_valout (out_valout),
    .o_out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic norm_pkg::result_t ref_result(logic [DW-1:0] v);
    norm_pkg::result_t r;
    int sq;
    sq = 0;
    if (v != '0) begin
      while (v[DW-1-sq] == 1'b0) sq++;
    end
    r.square = SW'(sq);
    r.valout = v << sq;
    r.div    = r.valout[DW-2:DW-3];
    r.zero   = (v == '0);
    return r;
  endfunction

  function automatic int ref_latency(int sq);
`ifdef NORM_SHIFT2_EN
    return 2 + (sq + 1) / 2;
`else
    return 2 + sq;
`endif
  endfunction

  function automatic int ref_pick(int ptr, logic [NUM_REQ-1:0] mask);
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (mask[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int oh_idx(logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] gen_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return DW'(1) << $urandom_range(0, DW - 1);
      default: return DW'($urandom);
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = NUM_REQ - 1;
  endtask

  // Single-requester transaction; returns what the DUT produced.
  task automatic do_txn(input int k, input logic [DW-1:0] val,
                        output int gnt, output int lat, output norm_pkg::result_t obs,
                        output logic [IDW-1:0] id);
    int n;
    gnt = -1; lat = -1; obs = '0; id = '0;
    req_data[k*DW +: DW] = val;
    req_valid[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    if (req_ready != '0) begin
      gnt = oh_idx(req_ready);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      if (out_valid) begin
        lat = n;
        obs.square = out_square; obs.div = out_div;
        obs.valout = out_valout; obs.zero = out_zero;
        id = out_id;
      end
    end
    req_valid[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (req_ready !== '0) $display("FAIL reset_ready got %b want 0", req_ready); else n_pass++;
    n_total++;
    if ({out_id, out_square, out_div, out_valout, out_zero} !== '0)
      $display("FAIL reset_outs got id=%h sq=%h div=%h val=%h z=%b want all 0",
               out_id, out_square, out_div, out_valout, out_zero);
    else n_pass++;
    req_valid = '1;
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant got %b want 0001", req_ready); else n_pass++;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int ks[4];
    logic [DW-1:0] vs[4];
    int gnt, lat;
    norm_pkg::result_t obs, exp;
    logic [IDW-1:0] id;
    ks = '{0, 1, 2, 3};
    vs = '{10'h200, 10'h0B4, 10'h001, 10'h000};
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp = ref_result(vs[t]);
      do_txn(ks[t], vs[t], gnt, lat, obs, id);
      n_total++; if (gnt !== ks[t]) $display("FAIL dir%0d_grant got %0d want %0d", t, gnt, ks[t]); else n_pass++;
      n_total++; if (obs !== exp) $display("FAIL dir%0d_result got %h want %h", t, obs, exp); else n_pass++;
      n_total++; if (id !== IDW'(ks[t])) $display("FAIL dir%0d_id got %0d want %0d", t, id, ks[t]); else n_pass++;
      n_total++;
      if (lat !== ref_latency(int'(exp.square)))
        $display("FAIL dir%0d_latency got %0d want %0d", t, lat, ref_latency(int'(exp.square)));
      else n_pass++;
    end
  endtask

  task automatic test_fairness();
    int got[5];
    int gcyc[5];
    int ng, m, e;
    apply_reset();
    for (int k = 0; k < NUM_REQ; k++) req_data[k*DW +: DW] = 10'h3FF;
    req_valid = '1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_total++;
        if (out_square !== '0 || out_valout !== 10'h3FF)
          $display("FAIL fair_result got sq=%0d val=%h want sq=0 val=3ff", out_square, out_valout);
        else n_pass++;
      end
      if (req_ready != '0) begin
        n_total++; if ($countones(req_ready) != 1) $display("FAIL fair_onehot got %b want one-hot", req_ready); else n_pass++;
        got[ng] = oh_idx(req_ready);
        gcyc[ng] = c;
        if (ng > 0) begin
          n_total++;
          if (gcyc[ng] - gcyc[ng-1] != 3) $display("FAIL fair_interval got %0d want 3", gcyc[ng] - gcyc[ng-1]); else n_pass++;
        end
        ng++;
        if (ng == 5) req_valid = '0;
      end
    end
    req_valid = '0;
    n_total++; if (ng != 5) $display("FAIL fair_count got %0d want 5", ng); else n_pass++;
    m = NUM_REQ - 1;
    for (int i = 0; i < ng; i++) begin
      e = ref_pick(m, '1);
      n_total++; if (got[i] != e) $display("FAIL fair_order%0d got %0d want %0d", i, got[i], e); else n_pass++;
      m = e;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    norm_pkg::result_t exp;
    int n;
    apply_reset();
    exp = ref_result(10'h0B4);
    out_ready = 1'b0;
    req_data[1*DW +: DW] = 10'h0B4;
    req_valid = 4'b0010;
    @(negedge clk);
    n_total++; if (req_ready !== 4'b0010) $display("FAIL bp_grant got %b want 0010", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = 4'b0001;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || out_valout !== exp.valout || out_square !== exp.square ||
          out_div !== exp.div || out_id !== 2'd1 || req_ready !== '0)
        $display("FAIL bp_hold%0d got v=%b val=%h sq=%0d div=%b id=%0d rdy=%b want v=1 val=%h sq=%0d div=%b id=1 rdy=0",
                 c, out_valid, out_valout, out_square, out_div, out_id, req_ready, exp.valout, exp.square, exp.div);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== '0) $display("FAIL bp_handshake_ready got %b want 0", req_ready); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drop got %b want 0", out_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL bp_next_grant got %b want 0001", req_ready); else n_pass++;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    int n;
    apply_reset();
    req_data[2*DW +: DW] = 10'h001;
    req_valid = 4'b0100;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_data[0*DW +: DW] = 10'h000;
    req_data[3*DW +: DW] = 10'h000;
    req_valid = 4'b1001;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rms_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL rms_grant got %b want 0001", req_ready); else n_pass++;
    @(posedge clk); #1;
    req_valid = '0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    n_total++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_zero !== 1'b1 || n != 2)
      $display("FAIL rms_result got v=%b id=%0d z=%b lat=%0d want v=1 id=0 z=1 lat=2", out_valid, out_id, out_zero, n);
    else n_pass++;
    @(posedge clk); #1;
    m_ptr = 0;
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] mask, eo;
    logic [DW-1:0] vals[NUM_REQ];
    norm_pkg::result_t exp;
    int eg, g, n, guard, stall;
    apply_reset();
    for (int r = 0; r < 25; r++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int k = 0; k < NUM_REQ; k++) begin
        vals[k] = gen_val();
        req_data[k*DW +: DW] = vals[k];
      end
      req_valid = mask;
      guard = 0;
      while (mask != '0 && guard < 8) begin
        guard++;
        out_ready = 1'b0;
        eg = ref_pick(m_ptr, mask);
        eo = '0;
        eo[eg] = 1'b1;
        @(negedge clk);
        n_total++; if (req_ready !== eo) $display("FAIL rnd_grant got %b want %b", req_ready, eo); else n_pass++;
        if (req_ready == '0) break;
        g = oh_idx(req_ready);
        @(posedge clk); #1;
        mask[g] = 1'b0;
        req_valid[g] = 1'b0;
        m_ptr = eg;
        exp = ref_result(vals[eg]);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        n_total++;
        if (!out_valid || n != ref_latency(int'(exp.square)))
          $display("FAIL rnd_latency got %0d want %0d", n, ref_latency(int'(exp.square)));
        else n_pass++;
        n_total++; if (out_id !== IDW'(eg)) $display("FAIL rnd_id got %0d want %0d", out_id, eg); else n_pass++;
        n_total++;
        if ({out_square, out_div, out_valout, out_zero} !== exp)
          $display("FAIL rnd_result in=%h got sq=%0d div=%b val=%h z=%b want sq=%0d div=%b val=%h z=%b",
                   vals[eg], out_square, out_div, out_valout, out_zero, exp.square, exp.div, exp.valout, exp.zero);
        else n_pass++;
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          n_total++;
          if (out_valid !== 1'b1 || {out_square, out_div, out_valout, out_zero} !== exp || req_ready !== '0)
            $display("FAIL rnd_stall got v=%b val=%h rdy=%b want v=1 val=%h rdy=0", out_valid, out_valout, req_ready, exp.valout);
          else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
      end
      req_valid = '0;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_fairness();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
